// File: rtl/ivl_uvm_ovl_clk_div_pkg.sv
// Shared types for the clock divider bank: channel state, config record and
// the config clamp applied when a write is captured.
package ivl_uvm_ovl_clk_div_pkg;

  localparam int CLK_DIV_CNT_W = 16;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} ch_state_e;

  typedef struct packed {
    logic [CLK_DIV_CNT_W-1:0] div;
    logic [CLK_DIV_CNT_W-1:0] high;
    logic [CLK_DIV_CNT_W-1:0] phase;
  } clk_div_cfg_t;

  localparam clk_div_cfg_t CFG_RESET = '{
    div:   CLK_DIV_CNT_W'(2),
    high:  CLK_DIV_CNT_W'(1),
    phase: CLK_DIV_CNT_W'(0)
  };

  // A zero period runs as period 1; an out-of-range phase starts at 0.
  function automatic clk_div_cfg_t normalize_cfg(input clk_div_cfg_t c);
    clk_div_cfg_t r;
    r = c;
    if (r.div == '0) r.div = CLK_DIV_CNT_W'(1);
    if (r.phase >= r.div) r.phase = '0;
    return r;
  endfunction

endpackage

// File: rtl/ivl_uvm_ovl_clk_div_ch.sv
// One divider channel: run/drain FSM, period counter, pending/active config.
// Optional tick counter under IVL_UVM_OVL_CLK_DIV_BANK_EDGE_CNT_EN.
//
// state | meaning
// IDLE  | stopped, cnt=0, output low; pending config applies immediately
// RUN   | counting, output follows cnt<high; pending applies at period end
// DRAIN | enable dropped while high; finish the high phase, then IDLE
module ivl_uvm_ovl_clk_div_ch
  import ivl_uvm_ovl_clk_div_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  clk_div_cfg_t wr_cfg,
  input  logic         en,
  output logic         clk_out,
  output logic         tick,
  output logic         busy
`ifdef IVL_UVM_OVL_CLK_DIV_BANK_EDGE_CNT_EN
  ,
  output logic [31:0]  edge_cnt
`endif
);

  localparam logic [CLK_DIV_CNT_W-1:0] ONE = CLK_DIV_CNT_W'(1);

  ch_state_e                state, state_nx;
  logic [CLK_DIV_CNT_W-1:0] cnt, cnt_nx, cnt_inc;
  clk_div_cfg_t             act, act_nx, pend;
  logic                     pend_vld, apply, boundary, fall;
  logic                     busy_nx, clk_nx, tick_nx;

  always_comb begin
    state_nx = state;
    act_nx   = act;
    apply    = 1'b0;
    boundary = (cnt == act.div - ONE);
    cnt_inc  = boundary ? '0 : cnt + ONE;

    if (pend_vld && (state == IDLE || boundary)) begin
      act_nx = pend;
      apply  = 1'b1;
    end

    // Output falls where the count reaches high; a constant-high channel
    // only "falls" at the period wrap.
    if (act_nx.high >= act_nx.div) fall = (cnt_inc == '0);
    else                           fall = (cnt_inc == act_nx.high);

    cnt_nx = cnt_inc;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (en) begin
          state_nx = RUN;
          cnt_nx   = act_nx.phase;
        end
      end
      RUN: begin
        if (!en) begin
          if (!clk_out || fall) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else begin
            state_nx = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (en) begin
          state_nx = RUN;
        end else if (fall) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase

    busy_nx = (state_nx != IDLE);
    clk_nx  = busy_nx && (cnt_nx < act_nx.high);
    // Period-1 output is a constant level: only its first cycle is an edge.
    tick_nx = busy_nx && (cnt_nx == '0) && (act_nx.high != '0) &&
              !((act_nx.div == ONE) && (state != IDLE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      act      <= CFG_RESET;
      pend     <= CFG_RESET;
      pend_vld <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      act     <= act_nx;
      clk_out <= clk_nx;
      tick    <= tick_nx;
      busy    <= busy_nx;
      if (wr) begin
        pend     <= normalize_cfg(wr_cfg);
        pend_vld <= 1'b1;
      end else if (apply) begin
        pend_vld <= 1'b0;
      end
    end
  end

`ifdef IVL_UVM_OVL_CLK_DIV_BANK_EDGE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      edge_cnt <= '0;
    else if (state == IDLE && state_nx == RUN)
      edge_cnt <= {31'd0, tick_nx};
    else if (tick_nx && edge_cnt != 32'hFFFF_FFFF)
      edge_cnt <= edge_cnt + 32'd1;
  end
`endif

endmodule

// File: rtl/ivl_uvm_ovl_clk_div_bank.sv
// Bank of NUM_CH independent programmable clock dividers sharing one config port.
// Define IVL_UVM_OVL_CLK_DIV_BANK_EDGE_CNT_EN to add per-channel tick counters.
module ivl_uvm_ovl_clk_div_bank
  import ivl_uvm_ovl_clk_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CLK_DIV_CNT_W,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic [CNT_W-1:0]  cfg_phase,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] busy
`ifdef IVL_UVM_OVL_CLK_DIV_BANK_EDGE_CNT_EN
  ,
  output logic [NUM_CH*32-1:0] edge_cnt
`endif
);

  clk_div_cfg_t wr_cfg;
  assign wr_cfg = '{div: cfg_div, high: cfg_high, phase: cfg_phase};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr;
    assign wr = cfg_we && (cfg_ch == CH_W'(i));

    ivl_uvm_ovl_clk_div_ch u_ch (
      .clk      (clk),
      .rst      (rst),
      .wr       (wr),
      .wr_cfg   (wr_cfg),
      .en       (ch_en[i]),
      .clk_out  (clk_out[i]),
      .tick     (tick[i]),
      .busy     (busy[i])
`ifdef IVL_UVM_OVL_CLK_DIV_BANK_EDGE_CNT_EN
      ,
      .edge_cnt (edge_cnt[i*32 +: 32])
`endif
    );
  end

endmodule

// File: tb/tb_ivl_uvm_ovl_clk_div_bank.sv
// Directed bench for the clock divider bank; expected waveforms are queued
// per cycle and checked by an independent negedge monitor.
module tb_ivl_uvm_ovl_clk_div_bank;

  localparam int NUM_CH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [1:0]        cfg_ch;
  logic [15:0]       cfg_div, cfg_high, cfg_phase;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] clk_out, tick, busy;
`ifdef IVL_UVM_OVL_CLK_DIV_BANK_EDGE_CNT_EN
  logic [NUM_CH*32-1:0] edge_cnt;
`endif

  ivl_uvm_ovl_clk_div_bank #(.NUM_CH(NUM_CH), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .cfg_phase (cfg_phase),
    .ch_en     (ch_en),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy)
`ifdef IVL_UVM_OVL_CLK_DIV_BANK_EDGE_CNT_EN
    ,
    .edge_cnt  (edge_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          ch;
    string       name;
    logic        chk_edge;
    logic        c, t, b;
    logic [31:0] edge_v;
  } exp_t;

  exp_t sbq[$];
  exp_t keep_q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every queued expectation that falls due this cycle.
  always @(negedge clk) begin
    keep_q = {};
    foreach (sbq[i]) begin
      if (sbq[i].cyc == cyc) begin
        checks++;
        if (sbq[i].chk_edge) begin
`ifdef IVL_UVM_OVL_CLK_DIV_BANK_EDGE_CNT_EN
          if (edge_cnt[sbq[i].ch*32 +: 32] !== sbq[i].edge_v) begin
            errors++;
            $display("FAIL %s ch%0d cyc=%0d edge_cnt got %0d want %0d", sbq[i].name,
                     sbq[i].ch, cyc, edge_cnt[sbq[i].ch*32 +: 32], sbq[i].edge_v);
          end
`endif
        end else if (clk_out[sbq[i].ch] !== sbq[i].c || tick[sbq[i].ch] !== sbq[i].t ||
                     busy[sbq[i].ch] !== sbq[i].b) begin
          errors++;
          $display("FAIL %s ch%0d cyc=%0d clk/tick/busy got %b%b%b want %b%b%b",
                   sbq[i].name, sbq[i].ch, cyc, clk_out[sbq[i].ch], tick[sbq[i].ch],
                   busy[sbq[i].ch], sbq[i].c, sbq[i].t, sbq[i].b);
        end
      end else if (sbq[i].cyc < cyc || done) begin
        checks++;
        errors++;
        $display("FAIL %s ch%0d cyc=%0d expectation never checked (now %0d)",
                 sbq[i].name, sbq[i].ch, sbq[i].cyc, cyc);
      end else begin
        keep_q.push_back(sbq[i]);
      end
    end
    sbq = keep_q;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int ch, input int dv, input int hi, input int ph);
    cfg_we    = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_div   = 16'(dv);
    cfg_high  = 16'(hi);
    cfg_phase = 16'(ph);
    step(1);
    cfg_we    = 1'b0;
  endtask

  task automatic push_wave(input string name, input int ch, input int start,
                           input string cs, input string ts, input string bs);
    exp_t e;
    for (int i = 0; i < cs.len(); i++) begin
      e.cyc      = start + i;
      e.ch       = ch;
      e.name     = name;
      e.chk_edge = 1'b0;
      e.c        = (cs[i] == "1");
      e.t        = (ts[i] == "1");
      e.b        = (bs[i] == "1");
      e.edge_v   = '0;
      sbq.push_back(e);
    end
  endtask

  task automatic push_edge(input string name, input int ch, input int at, input int v);
    exp_t e;
    e.cyc = at; e.ch = ch; e.name = name; e.chk_edge = 1'b1;
    e.c = 1'b0; e.t = 1'b0; e.b = 1'b0; e.edge_v = 32'(v);
    sbq.push_back(e);
  endtask

  int t, u;

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0;
    cfg_div = '0; cfg_high = '0; cfg_phase = '0; ch_en = '0;
    step(3);
    for (int ch = 0; ch < NUM_CH; ch++) push_wave("reset", ch, cyc, "0", "0", "0");
    rst = 1'b0;
    step(1);

    // ch0 div=4 high=2 phase=0
    cfg_write(0, 4, 2, 0);
    step(1);
    t = cyc;
    ch_en[0] = 1'b1;
    push_wave("idle_before_en", 0, t, "0", "0", "0");
    push_wave("div4_run", 0, t + 1, "110011001100", "100010001000", "111111111111");
    push_wave("retune_6_3", 0, t + 13, "1100111000111000", "1000100000100000",
              "1111111111111111");
    push_wave("boundary_write", 0, t + 29, "11001100", "10001000", "11111111");
    push_wave("drain", 0, t + 37, "1100", "1000", "1100");
    push_wave("drain_reenable", 0, t + 41, "11001100", "10001000", "11111111");
    step(14);
    cfg_write(0, 6, 3, 0);          // mid-period (cnt=1)
    step(7);
    cfg_write(0, 4, 2, 0);          // in a boundary cycle (cnt=5)
    step(14);
    ch_en[0] = 1'b0;                // dropped at cnt=0 while high
    step(3);
    ch_en[0] = 1'b1;
    step(1);
    ch_en[0] = 1'b0;
    step(1);
    ch_en[0] = 1'b1;                // back on while draining

    // ch1 div=5 high=2 phase=3
    step(1);
    cfg_write(1, 5, 2, 3);
    step(1);
    u = cyc;
    ch_en[1] = 1'b1;
    push_wave("phase3", 1, u, "000110001", "000100001", "011111111");

    // Corner configs on ch2/ch3
    cfg_write(2, 0, 1, 0);
    step(1);
    ch_en[2] = 1'b1;
    push_wave("div0_const_hi", 2, u + 2, "011111", "010000", "011111");
    cfg_write(3, 4, 0, 0);
    step(1);
    ch_en[3] = 1'b1;
    push_wave("high0_const_lo", 3, u + 4, "00000", "00000", "01111");
    step(4);
    ch_en[2] = 1'b0;
    ch_en[3] = 1'b0;
    push_wave("const_hi_stop", 2, u + 8, "10", "00", "10");
    push_wave("const_lo_stop", 3, u + 9, "0", "0", "0");
    step(1);
    cfg_write(2, 4, 2, 9);
    step(1);
    ch_en[2] = 1'b1;
    push_wave("phase_clamp", 2, u + 11, "011001", "010001", "011111");

    // Reset mid-run with a write still pending on ch1
    step(6);
    cfg_write(1, 7, 3, 0);
    rst = 1'b1;
    ch_en = '0;
    for (int ch = 0; ch < NUM_CH; ch++) push_wave("mid_reset", ch, u + 19, "0", "0", "0");
`ifdef IVL_UVM_OVL_CLK_DIV_BANK_EDGE_CNT_EN
    push_edge("edge_after_reset", 0, u + 19, 0);
    push_edge("edge_after_reset", 1, u + 19, 0);
    push_edge("edge_five_ticks", 1, u + 30, 5);
`endif
    step(1);
    rst = 1'b0;
    step(1);
    ch_en[1] = 1'b1;                // must run with reset config div=2 high=1
    push_wave("pending_discarded", 1, u + 20, "01010101010", "01010101010",
              "01111111111");
    step(11);

    done = 1'b1;
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
